// File: rtl/sum_result_pkg.sv
// Shared constants and helpers for the sum_result_fifo result buffer.
package sum_result_pkg;
    localparam int OVF_CNT_W = 8;
    localparam int ACC_EXT_W = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sum_result_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module sum_result_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sum_result_fifo.sv
// First-word-fall-through result FIFO with drop counter behind the adder stage.
// Define SUM_RESULT_ACC_EN to add the acc_clear/acc running accumulator.
module sum_result_fifo
    import sum_result_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [PW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic [OVF_CNT_W-1:0] overflow_cnt
`ifdef SUM_RESULT_ACC_EN
    ,
    input  logic                 acc_clear,
    output logic [W+ACC_EXT_W-1:0] acc
`endif
);
    localparam int AW = PW - 1;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OVF_CNT_W-1:0] ovf_q, ovf_d;
    logic                 push, pop, drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign out_valid    = !empty;
    assign overflow_cnt = ovf_q;

    always_comb begin
        pop      = out_valid && out_ready;
        push     = in_valid && (!full || pop);
        drop     = in_valid && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ovf_d    = (drop && ovf_q != '1) ? ovf_q + OVF_CNT_W'(1) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    sum_result_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (out_data)
    );

`ifdef SUM_RESULT_ACC_EN
    logic [W+ACC_EXT_W-1:0] acc_q, acc_d, pop_ext;

    always_comb begin
        pop_ext = {{ACC_EXT_W{1'b0}}, out_data};
        acc_d   = acc_q;
        // A clear coinciding with a pop restarts the total at the popped value.
        if (acc_clear)  acc_d = pop ? pop_ext : '0;
        else if (pop)   acc_d = acc_q + pop_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;
`endif
endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed self-checking bench for sum_result_fifo with a queue scoreboard.
module tb_sum_result_fifo;
    localparam int W = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   count;
    logic         full;
    logic         empty;
    logic [7:0]   overflow_cnt;
`ifdef SUM_RESULT_ACC_EN
    logic         acc_clear;
    logic [15:0]  acc;
`endif

    int nerr = 0;
    int nchk = 0;

    logic [W-1:0] sb[$];
    int           ovf_m;
    logic [15:0]  acc_m;
    logic         acc_clr_m;

    always #5 clk = ~clk;

    sum_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_cnt (overflow_cnt)
`ifdef SUM_RESULT_ACC_EN
        ,
        .acc_clear    (acc_clear),
        .acc          (acc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        chk("count", {29'b0, count}, sb.size());
        chk("full", {31'b0, full}, {31'b0, sb.size() == DEPTH});
        chk("empty", {31'b0, empty}, {31'b0, sb.size() == 0});
        chk("overflow_cnt", {24'b0, overflow_cnt}, ovf_m);
        if (sb.size() != 0) chk("out_data", {24'b0, out_data}, {24'b0, sb[0]});
`ifdef SUM_RESULT_ACC_EN
        chk("acc", {16'b0, acc}, {16'b0, acc_m});
`endif
    endtask

    // One clock: drive at negedge, check settled outputs, advance model at posedge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic rdy);
        logic         pop;
        logic [W-1:0] head;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
`ifdef SUM_RESULT_ACC_EN
        acc_clear = acc_clr_m;
`endif
        check_state();
        @(posedge clk);
        pop  = rdy && sb.size() != 0;
        head = pop ? sb[0] : '0;
        if (pop) void'(sb.pop_front());
        if (iv && (sb.size() < DEPTH)) sb.push_back(d);
        else if (iv && ovf_m < 255) ovf_m++;
        if (acc_clr_m) acc_m = pop ? {8'b0, head} : 16'h0;
        else if (pop)  acc_m = acc_m + {8'b0, head};
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hAA;
        out_ready = 1'b1;
        acc_clr_m = 1'b0;
`ifdef SUM_RESULT_ACC_EN
        acc_clear = 1'b0;
`endif
        ovf_m = 0;
        acc_m = '0;
        sb.delete();

        // 1. Reset held three cycles while the inputs are active
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_empty", {31'b0, empty}, 32'd1);
            chk("rst_count", {29'b0, count}, 32'd0);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step(1'b0, 8'h00, 1'b0);

        // 2. Ordering
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        step(1'b1, 8'h56, 1'b0);
        chk("ord_count3", {29'b0, count}, 32'd3);
        chk("ord_head", {24'b0, out_data}, 32'h12);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("ord_empty", {31'b0, empty}, 32'd1);

        // 3. Overflow: fifth push is dropped
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
        chk("ovf_full", {31'b0, full}, 32'd1);
        chk("ovf_count4", {29'b0, count}, 32'd4);
        chk("ovf_cnt1", {24'b0, overflow_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // 4. Full with simultaneous push and pop: no drop
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h09, 1'b1);
        chk("fp_count4", {29'b0, count}, 32'd4);
        chk("fp_ovf", {24'b0, overflow_cnt}, 32'd1);
        chk("fp_head", {24'b0, out_data}, 32'h02);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // 3 (cont). Saturation of the drop counter
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 1'b0);
        chk("ovf_sat", {24'b0, overflow_cnt}, 32'd255);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // 5. Wrap: one push and one pop per cycle across two pointer wraps
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b1);
            chk("wrap_count_le1", {31'b0, count <= 3'd1}, 32'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

`ifdef SUM_RESULT_ACC_EN
        // 6. Accumulator
        acc_clr_m = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        acc_clr_m = 1'b0;
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("acc_sum", {16'b0, acc}, 32'h0200);
        step(1'b1, 8'h05, 1'b0);
        acc_clr_m = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        acc_clr_m = 1'b0;
        chk("acc_clear_pop", {16'b0, acc}, 32'h0005);
        step(1'b0, 8'h00, 1'b0);
`endif

        // Mid-operation reset discards buffered entries
        step(1'b1, 8'h77, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        ovf_m = 0;
        acc_m = '0;
        step(1'b0, 8'h00, 1'b0);
        chk("midrst_empty", {31'b0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
